mc_control_unit: RTL and testbench
==================================

# mc_control_unit

Multi-cycle, parametrised successor to the single-cycle RISC-V control unit. It sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WB states and produces per-state datapath strobes. It waits on a memory ready handshake, with a watchdog timeout. It traps on illegal opcodes and counts retired instructions. It sits between the instruction register / memory interface and the multi-cycle datapath (PC, IR, register file, ALU, data memory).

## Interface
- MEM_TIMEOUT, 15: maximum consecutive cycles with mem_ready low in FETCH or MEM before trapping. Must be ≥1.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- arst  in  1  asynchronous, active-high reset.
- en  in  1  advance enable; low freezes the FSM and counters.
- opcode  in  7  instruction opcode from the IR; sampled only in DECODE.
- mem_ready  in  1  memory acknowledges the current mem_read/mem_write request.
- ir_write, pc_write, pc_write_cond, jump  out  1 each  PC/IR update strobes.
- mem_read, mem_write, mem_2_reg, reg_write, alu_src  out  1 each  datapath controls.
- alu_op  out  2  00 add, 01 sub, 10 R-type funct decode, 11 I-type funct decode.
- state  out  3  current state code.
- retire  out  1  one-cycle pulse on instruction completion.
- retire_cnt  out  CNT_W  retired-instruction count; wraps modulo 2^CNT_W.
- illegal, timeout  out  1 each  sticky trap cause flags.

## Operation
- Opcodes:
  - ALU_R 0110011, ALU_I 0010011, BRANCH_EQ 1100011, JUMP 1101111, LOAD 0000011, STORE 0100011.
  - All other opcodes are illegal.
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=7. State 6 is unused; if reached, go to TRAP.
- Internal registers: opc_q (7 bits) and wait counter wcnt (width $clog2(MEM_TIMEOUT+1)).
- Moore outputs, decoded from state and opc_q, gated by en. Any output not listed below is 0 in that state.
- IDLE: all outputs 0. If en=1, go to FETCH.
- FETCH: mem_read=1.
  - mem_ready=1: ir_write=1, pc_write=1, go to DECODE.
  - mem_ready=0: wcnt++.
- DECODE: opc_q←opcode.
  - Legal: go to EXEC.
  - Illegal: set illegal, go to TRAP.
- EXEC (uses opc_q):
  - ALU_R: alu_op=10, go to WB.
  - ALU_I: alu_op=11, alu_src=1, go to WB.
  - LOAD/STORE: alu_op=00, alu_src=1, go to MEM.
  - BRANCH_EQ: alu_op=01, pc_write_cond=1, retire=1, go to FETCH.
  - JUMP: jump=1, pc_write=1, go to WB.
- MEM:
  - LOAD: mem_read=1. STORE: mem_write=1.
  - mem_ready=1: LOAD goes to WB; STORE asserts retire=1 and goes to FETCH.
  - mem_ready=0: wcnt++.
- WB: reg_write=1; mem_2_reg=1 only for LOAD. retire=1, go to FETCH.
- Timeout: wcnt clears on every state change. If wcnt==MEM_TIMEOUT-1 and mem_ready=0 in FETCH or MEM, set timeout and go to TRAP.
- TRAP: all strobes 0. Stays in TRAP until arst; illegal/timeout hold their values.
- retire_cnt increments by 1 on each retire pulse.
- en=0:
  - state, opc_q, wcnt and retire_cnt hold.
  - All 1-bit control outputs and retire are 0; alu_op=00.
  - mem_ready is ignored.
  - state output still shows the frozen state.

## Timing
- Reset (arst high, asynchronous): state=IDLE, opc_q=0, wcnt=0, retire_cnt=0, illegal=0, timeout=0. All outputs 0, alu_op=00.
- Reset mid-instruction aborts it immediately, including any in-flight memory strobe. The aborted instruction is not retired.
- Transitions occur on the rising edge of clk. Outputs are combinational from registered state, so no mem_ready→output loop exists except the FETCH/MEM strobes qualified by mem_ready.
- Cycles per instruction with zero memory wait (FETCH→retire inclusive):
  - branch 3; R, I, store and jump 4; load 5.
  - Each wait cycle adds 1.
- After reset release, the first FETCH starts 1 cycle after IDLE (en=1).
- mem_ready is sampled only in FETCH/MEM with en=1. A ready arriving in the same cycle the counter would expire wins (no trap).
- retire and a retire_cnt wrap in the same edge is legal: the count goes from 2^CNT_W-1 to 0.

## Test plan
- Reset, en=1, mem_ready=1, opcode=0110011: state sequence 0,1,2,3,5,1. reg_write=1 only in WB, alu_op=10 in EXEC, retire_cnt=1 after 5 cycles.
- LOAD with mem_ready low for 3 MEM cycles (MEM_TIMEOUT=15): mem_read held for 4 MEM cycles, then WB with mem_2_reg=1, total 8 cycles FETCH→retire.
- Branch then store back-to-back, zero wait: retire pulses at cycles 3 and 7, pc_write_cond=1 only in branch EXEC, mem_write=1 for 1 cycle.
- opcode=1111111: DECODE→TRAP, illegal=1, all strobes 0 for 20 further cycles, retire_cnt unchanged.
- mem_ready held 0 in FETCH with MEM_TIMEOUT=4: TRAP entered after exactly 4 FETCH cycles, timeout=1. Repeat with ready on the 4th cycle: no trap.
- en dropped for 5 cycles in MEM of a store, then arst pulsed mid-WB of a later load: freeze shows no strobes and held state; reset returns all outputs and counters to 0.

Source files
------------

// File: rtl/mc_control_unit.sv
// Multi-cycle RISC-V control unit.
// Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB, drives the
// per-state datapath strobes, waits on a memory ready handshake guarded by a
// watchdog, traps on illegal opcodes and counts retired instructions.
module mc_control_unit #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             en,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             jump,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_2_reg,
    output logic             reg_write,
    output logic             alu_src,
    output logic [1:0]       alu_op,
    output logic [2:0]       state,
    output logic             retire,
    output logic [CNT_W-1:0] retire_cnt,
    output logic             illegal,
    output logic             timeout
);

    localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(MEM_TIMEOUT - 1);

    localparam logic [6:0] OP_ALU_R  = 7'b0110011;
    localparam logic [6:0] OP_ALU_I  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JUMP   = 7'b1101111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_RFUNC = 2'b10;
    localparam logic [1:0] ALU_IFUNC = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_UNUSED = 3'd6,
        S_TRAP   = 3'd7
    } state_t;

    state_t             state_q, state_d;
    logic [6:0]         opc_q, opc_d;
    logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
    logic [CNT_W-1:0]   retire_cnt_q, retire_cnt_d;
    logic               illegal_q, illegal_d;
    logic               timeout_q, timeout_d;
    logic               mem_wait;

    function automatic logic is_legal(input logic [6:0] op);
        return (op == OP_ALU_R) || (op == OP_ALU_I) || (op == OP_BRANCH) ||
               (op == OP_JUMP)  || (op == OP_LOAD)  || (op == OP_STORE);
    endfunction

    // Next-state, datapath strobes, watchdog and retire counter update.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned, which would infer a latch.
        state_d       = state_q;
        opc_d         = opc_q;
        wcnt_d        = wcnt_q;
        retire_cnt_d  = retire_cnt_q;
        illegal_d     = illegal_q;
        timeout_d     = timeout_q;
        mem_wait      = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        jump          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_2_reg     = 1'b0;
        reg_write     = 1'b0;
        alu_src       = 1'b0;
        alu_op        = ALU_ADD;
        retire        = 1'b0;

        if (en) begin
            case (state_q)
                S_IDLE: state_d = S_FETCH;
                S_FETCH: begin
                    mem_read = 1'b1;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = S_DECODE;
                    end else begin
                        mem_wait = 1'b1;
                    end
                end
                S_DECODE: begin
                    opc_d = opcode;
                    if (is_legal(opcode)) begin
                        state_d = S_EXEC;
                    end else begin
                        illegal_d = 1'b1;
                        state_d   = S_TRAP;
                    end
                end
                S_EXEC: begin
                    case (opc_q)
                        OP_ALU_R: begin
                            alu_op  = ALU_RFUNC;
                            state_d = S_WB;
                        end
                        OP_ALU_I: begin
                            alu_op  = ALU_IFUNC;
                            alu_src = 1'b1;
                            state_d = S_WB;
                        end
                        OP_LOAD, OP_STORE: begin
                            alu_op  = ALU_ADD;
                            alu_src = 1'b1;
                            state_d = S_MEM;
                        end
                        OP_BRANCH: begin
                            alu_op        = ALU_SUB;
                            pc_write_cond = 1'b1;
                            retire        = 1'b1;
                            state_d       = S_FETCH;
                        end
                        OP_JUMP: begin
                            jump     = 1'b1;
                            pc_write = 1'b1;
                            state_d  = S_WB;
                        end
                        default: state_d = S_TRAP;
                    endcase
                end
                S_MEM: begin
                    mem_read  = (opc_q == OP_LOAD);
                    mem_write = (opc_q != OP_LOAD);
                    if (mem_ready) begin
                        if (opc_q == OP_LOAD) begin
                            state_d = S_WB;
                        end else begin
                            retire  = 1'b1;
                            state_d = S_FETCH;
                        end
                    end else begin
                        mem_wait = 1'b1;
                    end
                end
                S_WB: begin
                    reg_write = 1'b1;
                    mem_2_reg = (opc_q == OP_LOAD);
                    retire    = 1'b1;
                    state_d   = S_FETCH;
                end
                S_TRAP:  state_d = S_TRAP;
                default: state_d = S_TRAP;
            endcase

            // A ready in the expiring cycle takes the normal path, so only a
            // still-low ready can trip the watchdog.
            if (mem_wait) begin
                if (wcnt_q == WCNT_MAX) begin
                    timeout_d = 1'b1;
                    state_d   = S_TRAP;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end

            if (state_d != state_q) begin
                wcnt_d = '0;
            end

            if (retire) begin
                retire_cnt_d = retire_cnt_q + 1'b1;
            end
        end
    end

    // State, opcode latch, watchdog, retire counter and sticky trap flags.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q      <= S_IDLE;
            opc_q        <= '0;
            wcnt_q       <= '0;
            retire_cnt_q <= '0;
            illegal_q    <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge value of the others.
            state_q      <= state_d;
            opc_q        <= opc_d;
            wcnt_q       <= wcnt_d;
            retire_cnt_q <= retire_cnt_d;
            illegal_q    <= illegal_d;
            timeout_q    <= timeout_d;
        end
    end

    assign state      = state_q;
    assign retire_cnt = retire_cnt_q;
    assign illegal    = illegal_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed scoreboard bench for mc_control_unit. Two instances share the
// stimulus: u_dut uses the default parameters, u_dut_t uses MEM_TIMEOUT=4 and
// CNT_W=2 to reach the watchdog and counter wrap quickly.
module tb_mc_control_unit;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] OP_B = 7'b1100011;
    localparam logic [6:0] OP_J = 7'b1101111;
    localparam logic [6:0] OP_L = 7'b0000011;
    localparam logic [6:0] OP_S = 7'b0100011;

    // Strobe vector bit masks: {ir_write, pc_write, pc_write_cond, jump,
    // mem_read, mem_write, mem_2_reg, reg_write, alu_src, retire}
    localparam logic [9:0] IRW  = 10'b10_0000_0000;
    localparam logic [9:0] PCW  = 10'b01_0000_0000;
    localparam logic [9:0] PCWC = 10'b00_1000_0000;
    localparam logic [9:0] JMP  = 10'b00_0100_0000;
    localparam logic [9:0] MRD  = 10'b00_0010_0000;
    localparam logic [9:0] MWR  = 10'b00_0001_0000;
    localparam logic [9:0] M2R  = 10'b00_0000_1000;
    localparam logic [9:0] REGW = 10'b00_0000_0100;
    localparam logic [9:0] ASRC = 10'b00_0000_0010;
    localparam logic [9:0] RET  = 10'b00_0000_0001;
    localparam logic [9:0] FOK  = IRW | PCW | MRD;

    typedef struct {
        string      tag;
        logic [2:0] st;
        logic [9:0] sb;
        logic [1:0] aop;
    } exp_t;

    logic       clk, arst, en, mem_ready;
    logic [6:0] opcode;
    logic       sel;

    logic        irw0, pcw0, pcwc0, jmp0, mrd0, mwr0, m2r0, regw0, asrc0, ret0, ill0, to0;
    logic [1:0]  aop0;
    logic [2:0]  st0;
    logic [31:0] cnt0;
    logic        irw1, pcw1, pcwc1, jmp1, mrd1, mwr1, m2r1, regw1, asrc1, ret1, ill1, to1;
    logic [1:0]  aop1;
    logic [2:0]  st1;
    logic [1:0]  cnt1;

    logic [9:0]  obs_sb;
    logic [2:0]  obs_st;
    logic [1:0]  obs_aop;
    logic [31:0] obs_cnt;
    logic        obs_ill, obs_to;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    mc_control_unit u_dut (
        .clk(clk), .arst(arst), .en(en), .opcode(opcode), .mem_ready(mem_ready),
        .ir_write(irw0), .pc_write(pcw0), .pc_write_cond(pcwc0), .jump(jmp0),
        .mem_read(mrd0), .mem_write(mwr0), .mem_2_reg(m2r0), .reg_write(regw0),
        .alu_src(asrc0), .alu_op(aop0), .state(st0), .retire(ret0),
        .retire_cnt(cnt0), .illegal(ill0), .timeout(to0)
    );

    mc_control_unit #(.MEM_TIMEOUT(4), .CNT_W(2)) u_dut_t (
        .clk(clk), .arst(arst), .en(en), .opcode(opcode), .mem_ready(mem_ready),
        .ir_write(irw1), .pc_write(pcw1), .pc_write_cond(pcwc1), .jump(jmp1),
        .mem_read(mrd1), .mem_write(mwr1), .mem_2_reg(m2r1), .reg_write(regw1),
        .alu_src(asrc1), .alu_op(aop1), .state(st1), .retire(ret1),
        .retire_cnt(cnt1), .illegal(ill1), .timeout(to1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observe whichever instance the current phase is exercising.
    always_comb begin
        if (sel) begin
            obs_sb  = {irw1, pcw1, pcwc1, jmp1, mrd1, mwr1, m2r1, regw1, asrc1, ret1};
            obs_st  = st1;
            obs_aop = aop1;
            obs_cnt = {30'd0, cnt1};
            obs_ill = ill1;
            obs_to  = to1;
        end else begin
            obs_sb  = {irw0, pcw0, pcwc0, jmp0, mrd0, mwr0, m2r0, regw0, asrc0, ret0};
            obs_st  = st0;
            obs_aop = aop0;
            obs_cnt = cnt0;
            obs_ill = ill0;
            obs_to  = to0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pop the oldest expectation and compare it with the live outputs.
    task automatic compare();
        exp_t e;
        if (exp_q.size() == 0) begin
            check("scoreboard_underflow", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check({e.tag, "_state"},  {29'd0, obs_st},  {29'd0, e.st});
            check({e.tag, "_strobe"}, {22'd0, obs_sb},  {22'd0, e.sb});
            check({e.tag, "_aluop"},  {30'd0, obs_aop}, {30'd0, e.aop});
        end
    endtask

    // Drive one cycle of inputs, queue its expected outputs, sample mid-cycle.
    task automatic step(input logic e_i, input logic r_i, input logic [6:0] o_i,
                        input logic [2:0] st, input logic [9:0] sb, input logic [1:0] aop,
                        input string tag);
        exp_t e;
        en        = e_i;
        mem_ready = r_i;
        opcode    = o_i;
        e.tag = tag; e.st = st; e.sb = sb; e.aop = aop;
        exp_q.push_back(e);
        @(negedge clk);
        compare();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        arst = 1'b1;
        en   = 1'b0;
        @(posedge clk);
        #1;
        arst = 1'b0;
    endtask

    initial begin
        exp_t e;
        sel = 1'b0; arst = 1'b1; en = 1'b0; mem_ready = 1'b0; opcode = 7'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", {29'd0, obs_st}, 32'd0);
        check("rst_strobe", {22'd0, obs_sb}, 32'd0);
        check("rst_cnt", obs_cnt, 32'd0);
        check("rst_flags", {30'd0, obs_ill, obs_to}, 32'd0);
        arst = 1'b0;

        // R-type: 0,1,2,3,5 then next fetch
        step(1, 1, 0,    3'd0, 10'd0,      2'b00, "r_idle");
        step(1, 1, 0,    3'd1, FOK,        2'b00, "r_fetch");
        step(1, 1, OP_R, 3'd2, 10'd0,      2'b00, "r_dec");
        step(1, 1, 0,    3'd3, 10'd0,      2'b10, "r_exec");
        step(1, 1, 0,    3'd5, REGW | RET, 2'b00, "r_wb");
        check("r_cnt", obs_cnt, 32'd1);

        // Branch then store, zero wait
        step(1, 1, 0,    3'd1, FOK,        2'b00, "b_fetch");
        step(1, 1, OP_B, 3'd2, 10'd0,      2'b00, "b_dec");
        step(1, 1, 0,    3'd3, PCWC | RET, 2'b01, "b_exec");
        step(1, 1, 0,    3'd1, FOK,        2'b00, "s_fetch");
        step(1, 1, OP_S, 3'd2, 10'd0,      2'b00, "s_dec");
        step(1, 1, 0,    3'd3, ASRC,       2'b00, "s_exec");
        step(1, 1, 0,    3'd4, MWR | RET,  2'b00, "s_mem");
        check("bs_cnt", obs_cnt, 32'd3);

        // Load with three wait cycles in MEM
        step(1, 1, 0,    3'd1, FOK,  2'b00, "l_fetch");
        step(1, 1, OP_L, 3'd2, 10'd0, 2'b00, "l_dec");
        step(1, 1, 0,    3'd3, ASRC, 2'b00, "l_exec");
        for (int i = 0; i < 3; i++) step(1, 0, 0, 3'd4, MRD, 2'b00, "l_wait");
        step(1, 1, 0,    3'd4, MRD,              2'b00, "l_mem");
        step(1, 1, 0,    3'd5, REGW | M2R | RET, 2'b00, "l_wb");
        check("l_cnt", obs_cnt, 32'd4);

        // I-type and jump
        step(1, 1, 0,    3'd1, FOK,        2'b00, "i_fetch");
        step(1, 1, OP_I, 3'd2, 10'd0,      2'b00, "i_dec");
        step(1, 1, 0,    3'd3, ASRC,       2'b11, "i_exec");
        step(1, 1, 0,    3'd5, REGW | RET, 2'b00, "i_wb");
        step(1, 1, 0,    3'd1, FOK,        2'b00, "j_fetch");
        step(1, 1, OP_J, 3'd2, 10'd0,      2'b00, "j_dec");
        step(1, 1, 0,    3'd3, JMP | PCW,  2'b00, "j_exec");
        step(1, 1, 0,    3'd5, REGW | RET, 2'b00, "j_wb");
        check("ij_cnt", obs_cnt, 32'd6);

        // Store frozen in MEM for five cycles; ready is ignored while frozen
        step(1, 1, 0,    3'd1, FOK,   2'b00, "f_fetch");
        step(1, 1, OP_S, 3'd2, 10'd0, 2'b00, "f_dec");
        step(1, 1, 0,    3'd3, ASRC,  2'b00, "f_exec");
        for (int i = 0; i < 5; i++) step(0, 1, 0, 3'd4, 10'd0, 2'b00, "freeze");
        check("freeze_cnt", obs_cnt, 32'd6);
        step(1, 1, 0,    3'd4, MWR | RET, 2'b00, "f_mem");
        check("f_cnt", obs_cnt, 32'd7);

        // Load aborted by reset in WB
        step(1, 1, 0,    3'd1, FOK,   2'b00, "a_fetch");
        step(1, 1, OP_L, 3'd2, 10'd0, 2'b00, "a_dec");
        step(1, 1, 0,    3'd3, ASRC,  2'b00, "a_exec");
        step(1, 1, 0,    3'd4, MRD,   2'b00, "a_mem");
        en = 1'b1; mem_ready = 1'b1;
        e.tag = "a_wb"; e.st = 3'd5; e.sb = REGW | M2R | RET; e.aop = 2'b00;
        exp_q.push_back(e);
        @(negedge clk);
        compare();
        #2 arst = 1'b1;
        #1;
        check("abort_state", {29'd0, obs_st}, 32'd0);
        check("abort_strobe", {22'd0, obs_sb}, 32'd0);
        check("abort_cnt", obs_cnt, 32'd0);
        @(posedge clk);
        #1;
        arst = 1'b0;
        check("abort_cnt_after", obs_cnt, 32'd0);

        // Illegal opcode traps and stays
        step(1, 1, 0,       3'd0, 10'd0, 2'b00, "x_idle");
        step(1, 1, 0,       3'd1, FOK,   2'b00, "x_fetch");
        step(1, 1, 7'h7F,   3'd2, 10'd0, 2'b00, "x_dec");
        for (int i = 0; i < 20; i++) step(1, i[0], OP_R, 3'd7, 10'd0, 2'b00, "x_trap");
        check("x_illegal", {31'd0, obs_ill}, 32'd1);
        check("x_timeout", {31'd0, obs_to}, 32'd0);
        check("x_cnt", obs_cnt, 32'd0);

        // Watchdog with MEM_TIMEOUT=4
        sel = 1'b1;
        pulse_reset();
        check("t_rst_flags", {30'd0, obs_ill, obs_to}, 32'd0);
        step(1, 0, 0, 3'd0, 10'd0, 2'b00, "t_idle");
        for (int i = 0; i < 4; i++) step(1, 0, 0, 3'd1, MRD, 2'b00, "t_fetch_wait");
        step(1, 0, 0, 3'd7, 10'd0, 2'b00, "t_trap");
        check("t_timeout", {31'd0, obs_to}, 32'd1);
        check("t_illegal", {31'd0, obs_ill}, 32'd0);

        // Ready on the expiring cycle wins, then four branches wrap CNT_W=2
        pulse_reset();
        step(1, 0, 0, 3'd0, 10'd0, 2'b00, "w_idle");
        for (int i = 0; i < 3; i++) step(1, 0, 0, 3'd1, MRD, 2'b00, "w_fetch_wait");
        step(1, 1, 0,    3'd1, FOK,        2'b00, "w_fetch_rdy");
        step(1, 1, OP_B, 3'd2, 10'd0,      2'b00, "w_dec");
        check("w_no_timeout", {31'd0, obs_to}, 32'd0);
        step(1, 1, 0,    3'd3, PCWC | RET, 2'b01, "w_exec");
        check("w_cnt1", obs_cnt, 32'd1);
        for (int k = 0; k < 3; k++) begin
            step(1, 1, 0,    3'd1, FOK,        2'b00, "wr_fetch");
            step(1, 1, OP_B, 3'd2, 10'd0,      2'b00, "wr_dec");
            step(1, 1, 0,    3'd3, PCWC | RET, 2'b01, "wr_exec");
            check("wrap_cnt", obs_cnt, 32'((k + 2) % 4));
        end

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
